// File: rtl/spi_master_byte.sv
// spi_master_byte: byte-oriented SPI mode-0 master (CPOL=0, CPHA=0).
// Exchanges one DATA_WIDTH word per valid/ready handshake and keeps /CS low
// across words until a word tagged last has completed.
// Build option: define SPI_MASTER_LOOPBACK_EN to sample mosi_o instead of
// miso_i (bring-up without a slave attached).
module spi_master_byte #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CLK_DIV    = 4
) (
   input  logic                  sysClk_i,
   input  logic                  reset_ni,
   input  logic [DATA_WIDTH-1:0] tx_data_i,
   input  logic                  tx_valid_i,
   input  logic                  tx_last_i,
   output logic                  tx_ready_o,
   output logic [DATA_WIDTH-1:0] rx_data_o,
   output logic                  rx_valid_o,
   output logic                  busy_o,
   output logic                  spiClk_o,
   output logic                  mosi_o,
   input  logic                  miso_i,
   output logic                  cs_no
);

   localparam int unsigned DW    = DATA_WIDTH;
   localparam int unsigned DIV_W = $clog2(CLK_DIV);
   localparam int unsigned BIT_W = $clog2(DATA_WIDTH);

   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(DATA_WIDTH - 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] SETUP = 3'd1;
   localparam logic [2:0] HIGH  = 3'd2;
   localparam logic [2:0] LOW   = 3'd3;
   localparam logic [2:0] GAP   = 3'd4;
   localparam logic [2:0] HOLD  = 3'd5;
   localparam logic [2:0] DESEL = 3'd6;

   logic [2:0]       state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   logic [DW-1:0]    tx_sh_q, tx_sh_d;
   logic [DW-1:0]    rx_sh_q, rx_sh_d;
   logic             last_q, last_d;
   logic             cs_d, sclk_d, mosi_d, rx_valid_d;
   logic [DW-1:0]    rx_data_d;
   logic             sample_bit;

   // Bit captured on every spiClk rising edge
`ifdef SPI_MASTER_LOOPBACK_EN
   logic unused_miso;
   assign unused_miso = miso_i;
   assign sample_bit  = mosi_o;
`else
   assign sample_bit  = miso_i;
`endif

   // Next-state and next-output logic for the byte sequencer
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      bit_d      = bit_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      last_d     = last_q;
      cs_d       = cs_no;
      sclk_d     = spiClk_o;
      mosi_d     = mosi_o;
      rx_data_d  = rx_data_o;
      rx_valid_d = 1'b0;

      if (div_q != '0) begin
         div_d = div_q - DIV_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (tx_valid_i) begin
               tx_sh_d = tx_data_i;
               last_d  = tx_last_i;
               mosi_d  = tx_data_i[DW-1];
               cs_d    = 1'b0;
               bit_d   = BIT_LOAD;
               div_d   = DIV_LOAD;
               state_d = SETUP;
            end
         end
         SETUP, LOW: begin
            if (div_q == '0) begin
               sclk_d  = 1'b1;
               rx_sh_d = {rx_sh_q[DW-2:0], sample_bit};
               div_d   = DIV_LOAD;
               state_d = HIGH;
            end
         end
         HIGH: begin
            if (div_q == '0) begin
               sclk_d = 1'b0;
               div_d  = DIV_LOAD;
               if (bit_q != '0) begin
                  tx_sh_d = {tx_sh_q[DW-2:0], 1'b0};
                  mosi_d  = tx_sh_q[DW-2];
                  bit_d   = bit_q - BIT_W'(1);
                  state_d = LOW;
               end else begin
                  rx_data_d  = rx_sh_q;
                  rx_valid_d = 1'b1;
                  state_d    = last_q ? HOLD : GAP;
               end
            end
         end
         GAP: begin
            // /CS stays low while waiting for the next byte of the frame
            if (tx_valid_i) begin
               tx_sh_d = tx_data_i;
               last_d  = tx_last_i;
               mosi_d  = tx_data_i[DW-1];
               bit_d   = BIT_LOAD;
               div_d   = DIV_LOAD;
               state_d = LOW;
            end
         end
         HOLD: begin
            if (div_q == '0) begin
               cs_d    = 1'b1;
               div_d   = DIV_LOAD;
               state_d = DESEL;
            end
         end
         DESEL: begin
            if (div_q == '0) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cs_d    = 1'b1;
            sclk_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs, synchronous active-low reset
   always_ff @(posedge sysClk_i) begin
      if (!reset_ni) begin
         state_q    <= IDLE;
         div_q      <= '0;
         bit_q      <= '0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         last_q     <= 1'b0;
         cs_no      <= 1'b1;
         spiClk_o   <= 1'b0;
         mosi_o     <= 1'b0;
         rx_data_o  <= '0;
         rx_valid_o <= 1'b0;
         tx_ready_o <= 1'b1;
         busy_o     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         last_q     <= last_d;
         cs_no      <= cs_d;
         spiClk_o   <= sclk_d;
         mosi_o     <= mosi_d;
         rx_data_o  <= rx_data_d;
         rx_valid_o <= rx_valid_d;
         tx_ready_o <= (state_d == IDLE) || (state_d == GAP);
         busy_o     <= (state_d != IDLE);
      end
   end

endmodule
